// File: rtl/maze_pkg.sv
// Shared maze constants and the tile-index helper used by the lookup arbiter.
// The MAZE_ARB_BOUNDS_EN build option is consumed in maze_lookup_arbiter.sv.
package maze_pkg;

  localparam int   MAZE_DIM   = 8;
  localparam int   MAZE_IDX_W = 6;
  localparam logic WALL       = 1'b1;

  function automatic logic [MAZE_IDX_W-1:0] tile_idx(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner and wraps.
// Owns last_gnt, which only moves when upd is strobed.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             upd,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] last_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= IDX_W'(N_REQ - 1);
    end else if (upd) begin
      last_gnt <= gnt_idx;
    end
  end

  // Grants are suppressed while reset is held so nothing is accepted into a dead pipeline.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (rst_n) begin
      for (int off = 1; off <= N_REQ; off++) begin
        cand = int'(last_gnt) + off;
        if (cand >= N_REQ) cand = cand - N_REQ;
        cand_idx = IDX_W'(cand);
        if (!found && req[cand_idx]) begin
          found         = 1'b1;
          gnt[cand_idx] = 1'b1;
          gnt_idx       = cand_idx;
        end
      end
    end
  end

endmodule

// File: rtl/maze_lookup_arbiter.sv
// Shares the registered maze wall ROM between movement requesters; fixed 3-cycle lookup.
// Build option MAZE_ARB_BOUNDS_EN: off-maze coordinates read as walls instead of wrapping.
module maze_lookup_arbiter
  import maze_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int COORD_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*COORD_W-1:0] req_row,
  input  logic [N_REQ*COORD_W-1:0] req_col,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic                     rsp_wall,
  output logic                     rom_en,
  output logic [MAZE_IDX_W-1:0]    rom_addr,
  input  logic                     rom_data
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic               grant_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic [COORD_W-1:0] sel_row;
  logic [COORD_W-1:0] sel_col;
  logic               sel_oob;

  logic               s1_valid, s2_valid;
  logic [IDX_W-1:0]   s1_tag, s2_tag;
  logic               s1_oob, s2_oob;
  logic [N_REQ-1:0]   tag_dec;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .upd     (grant_any),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign grant_any = |gnt;

  always_comb begin
    sel_row = '0;
    sel_col = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_row = req_row[i*COORD_W +: COORD_W];
        sel_col = req_col[i*COORD_W +: COORD_W];
      end
    end
  end

`ifdef MAZE_ARB_BOUNDS_EN
  assign sel_oob = (int'(sel_row) >= MAZE_DIM) || (int'(sel_col) >= MAZE_DIM);
`else
  // Upper coordinate bits are dropped so the maze wraps like a tunnel.
  logic unused_coord;
  assign sel_oob      = 1'b0;
  assign unused_coord = ^{sel_row, sel_col};
`endif

  always_comb begin
    tag_dec         = '0;
    tag_dec[s2_tag] = s2_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_tag    <= '0;
      s1_oob    <= 1'b0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      s2_valid  <= 1'b0;
      s2_tag    <= '0;
      s2_oob    <= 1'b0;
      rsp_valid <= '0;
      rsp_wall  <= 1'b0;
    end else begin
      s1_valid <= grant_any;
      s1_tag   <= gnt_idx;
      s1_oob   <= sel_oob;
      rom_en   <= grant_any && !sel_oob;
      if (grant_any) begin
        rom_addr <= tile_idx(sel_row[2:0], sel_col[2:0]);
      end
      s2_valid  <= s1_valid;
      s2_tag    <= s1_tag;
      s2_oob    <= s1_oob;
      rsp_valid <= tag_dec;
      if (s2_valid) begin
        rsp_wall <= s2_oob ? WALL : rom_data;
      end
    end
  end

endmodule

// File: tb/tb_maze_lookup_arbiter.sv
// Directed bench for maze_lookup_arbiter with a queue scoreboard and independent response monitor.
module tb_maze_lookup_arbiter;

  localparam int N_REQ   = 4;
  localparam int COORD_W = 4;

`ifdef MAZE_ARB_BOUNDS_EN
  localparam logic OOB_WALL = 1'b1;
  localparam logic OOB_EN   = 1'b0;
`else
  localparam logic OOB_WALL = 1'b0;
  localparam logic OOB_EN   = 1'b1;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*COORD_W-1:0] req_row;
  logic [N_REQ*COORD_W-1:0] req_col;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         rsp_valid;
  logic                     rsp_wall;
  logic                     rom_en;
  logic [5:0]               rom_addr;
  logic                     rom_data = 1'b0;

  // Walls at tiles 9, 10 and 30 only.
  logic [63:0] rom_img = 64'h0000_0000_4000_0600;

  typedef struct {
    logic [N_REQ-1:0] vld;
    logic             wall;
    int               due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  maze_lookup_arbiter #(
    .N_REQ   (N_REQ),
    .COORD_W (COORD_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_row   (req_row),
    .req_col   (req_col),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_wall  (rsp_wall),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_en) rom_data <= rom_img[rom_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid !== '0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b, expected none (cycle %0d)", rsp_valid, cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e.vld));
        chk("rsp_wall", 32'(rsp_wall), 32'(e.wall));
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic step(input logic [3:0] r, input logic [15:0] rr, input logic [15:0] cc,
                      input logic [3:0] eg, input logic ew, input bit push = 1'b1);
    @(posedge clk);
    #1;
    req     = r;
    req_row = rr;
    req_col = cc;
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(eg));
    if (push && eg != 4'b0) sb.push_back('{eg, ew, cyc + 3});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      req = '0;
      @(negedge clk);
      chk("gnt_idle", 32'(gnt), 32'h0);
    end
  endtask

  task automatic rom_chk(input logic en, input logic [5:0] addr);
    @(posedge clk);
    #1;
    req = '0;
    @(negedge clk);
    chk("rom_en", 32'(rom_en), 32'(en));
    if (en) chk("rom_addr", 32'(rom_addr), 32'(addr));
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    chk("rsp_valid_in_rst", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 4'hF;
    req_row = '0;
    req_col = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rom_en", 32'(rom_en), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_wall", 32'(rsp_wall), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = '0;

    // Single lookup: requester 0 at (1,1) -> tile 9, a wall.
    step(4'b0001, 16'h0001, 16'h0001, 4'b0001, 1'b1);
    rom_chk(1'b1, 6'd9);
    idle(3);
    rom_chk(1'b0, 6'd0);

    // All four requesting: r0 (0,0)=0, r1 (1,1)=1, r2 (1,2)=1, r3 (7,7)=0.
    rst_pulse();
    for (int k = 0; k < 8; k++) begin
      case (k % 4)
        0: step(4'hF, 16'h7110, 16'h7210, 4'b0001, 1'b0);
        1: step(4'hF, 16'h7110, 16'h7210, 4'b0010, 1'b1);
        2: step(4'hF, 16'h7110, 16'h7210, 4'b0100, 1'b1);
        default: step(4'hF, 16'h7110, 16'h7210, 4'b1000, 1'b0);
      endcase
    end

    // Requester 2 back-to-back with changing coordinates.
    step(4'b0100, 16'h0000, 16'h0000, 4'b0100, 1'b0);
    step(4'b0100, 16'h0100, 16'h0200, 4'b0100, 1'b1);
    step(4'b0100, 16'h0300, 16'h0600, 4'b0100, 1'b1);
    step(4'b0100, 16'h0700, 16'h0700, 4'b0100, 1'b0);

    // Requesters 1 and 3 only, starting from last_gnt=1.
    step(4'b0010, 16'h0010, 16'h0010, 4'b0010, 1'b1);
    step(4'b1010, 16'h7010, 16'h7010, 4'b1000, 1'b0);
    step(4'b1010, 16'h7010, 16'h7010, 4'b0010, 1'b1);
    step(4'b1010, 16'h7010, 16'h7010, 4'b1000, 1'b0);
    idle(4);

    // Three grants, then reset two cycles after the last: only the first response survives.
    step(4'hF, 16'h0000, 16'h0000, 4'b0001, 1'b0);
    step(4'hF, 16'h0000, 16'h0000, 4'b0010, 1'b0, 1'b0);
    step(4'hF, 16'h0000, 16'h0000, 4'b0100, 1'b0, 1'b0);
    idle(1);
    rst_pulse();
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk("rsp_after_rst", 32'(rsp_valid), 32'h0);
    end
    step(4'hF, 16'h0000, 16'h0000, 4'b0001, 1'b0);
    idle(4);

    // Out-of-maze coordinates: (9,2) and (0,8).
    step(4'b0010, 16'h0090, 16'h0020, 4'b0010, 1'b1);
    rom_chk(OOB_EN, 6'd10);
    step(4'b0010, 16'h0000, 16'h0080, 4'b0010, OOB_WALL);
    rom_chk(OOB_EN, 6'd0);
    idle(5);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
